// File: rtl/quant_scan_pkg.sv
// Shared definitions for the coefficient scan block: scan tables, FSM states
// and the scan-position lookup helper.
// Optional feature macro: QUANT_BLOCK_SCAN_INTERLACE_EN (adds the interlaced table selection).
package quant_scan_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } scan_state_e;

    localparam logic [5:0] LAST_IDX = 6'd63;

    localparam logic [5:0] PROG_SCAN [64] = '{
        6'd0,  6'd1,  6'd8,  6'd9,  6'd2,  6'd3,  6'd10, 6'd11,
        6'd16, 6'd17, 6'd24, 6'd25, 6'd18, 6'd19, 6'd26, 6'd27,
        6'd4,  6'd5,  6'd12, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14,
        6'd21, 6'd28, 6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd31,
        6'd32, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34, 6'd35, 6'd42,
        6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36, 6'd37, 6'd44,
        6'd51, 6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    localparam logic [5:0] INTL_SCAN [64] = '{
        6'd0,  6'd8,  6'd1,  6'd9,  6'd16, 6'd24, 6'd17, 6'd25,
        6'd2,  6'd10, 6'd3,  6'd11, 6'd18, 6'd26, 6'd19, 6'd27,
        6'd32, 6'd40, 6'd33, 6'd34, 6'd41, 6'd48, 6'd56, 6'd49,
        6'd42, 6'd35, 6'd43, 6'd50, 6'd57, 6'd58, 6'd51, 6'd59,
        6'd4,  6'd12, 6'd5,  6'd6,  6'd13, 6'd20, 6'd28, 6'd21,
        6'd14, 6'd7,  6'd15, 6'd22, 6'd29, 6'd36, 6'd44, 6'd37,
        6'd30, 6'd23, 6'd31, 6'd38, 6'd45, 6'd52, 6'd60, 6'd53,
        6'd46, 6'd39, 6'd47, 6'd54, 6'd61, 6'd62, 6'd55, 6'd63
    };

    // Map scan position k to the flat block position row*8+col.
    function automatic logic [5:0] scan_pos(input logic intl, input logic [5:0] k);
        logic [5:0] pos;
        if (intl) begin
            pos = INTL_SCAN[k];
        end else begin
            pos = PROG_SCAN[k];
        end
        return pos;
    endfunction

endpackage

// File: rtl/quant_block_pingpong.sv
// Two-bank block store with per-bank full flags and scan-mode flags.
// Writes fill banks alternately; reads drain them in the same order.
module quant_block_pingpong
    import quant_scan_pkg::*;
#(
    parameter int DATA_WIDTH = 32
)
(
    input  logic                         CLOCK,
    input  logic                         RESET,
    input  logic                         wr_en_i,
    input  logic signed [DATA_WIDTH-1:0] wr_data_i [8][8],
    input  logic                         wr_intl_i,
    input  logic                         drain_i,
    input  logic [5:0]                   rd_pos_i,
    output logic                         wr_ready_o,
    output logic                         rd_full_o,
    output logic                         nxt_full_o,
    output logic                         rd_intl_o,
    output logic signed [DATA_WIDTH-1:0] rd_coef_o,
    output logic signed [DATA_WIDTH-1:0] nxt_head_o
);

    logic signed [DATA_WIDTH-1:0] bank_q [2][8][8];
    logic [1:0] intl_q;
    logic [1:0] full_q;
    logic [1:0] full_d;
    logic       wr_ptr_q;
    logic       rd_ptr_q;

    // Next full flags: a write into a bank wins over a drain of the same bank.
    always_comb begin
        full_d = full_q;
        if (drain_i) begin
            full_d[rd_ptr_q] = 1'b0;
        end else begin
            full_d[rd_ptr_q] = full_q[rd_ptr_q];
        end
        if (wr_en_i) begin
            full_d[wr_ptr_q] = 1'b1;
        end else begin
            full_d[wr_ptr_q] = full_d[wr_ptr_q];
        end
    end

    // Bank bookkeeping: full flags, write/read pointers and stored scan mode.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            full_q   <= 2'b00;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            intl_q   <= 2'b00;
        end else begin
            full_q <= full_d;
            if (wr_en_i) begin
                wr_ptr_q         <= ~wr_ptr_q;
                intl_q[wr_ptr_q] <= wr_intl_i;
            end
            if (drain_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Coefficient storage; contents are only meaningful while the bank is full.
    always_ff @(posedge CLOCK) begin
        if (wr_en_i) begin
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    bank_q[wr_ptr_q][r][c] <= wr_data_i[r][c];
                end
            end
        end
    end

    // Read-side views and write readiness (a bank draining this cycle counts as free).
    always_comb begin
        wr_ready_o = !full_q[wr_ptr_q] || (drain_i && (wr_ptr_q == rd_ptr_q));
        rd_full_o  = full_q[rd_ptr_q];
        nxt_full_o = full_q[~rd_ptr_q];
        rd_intl_o  = intl_q[rd_ptr_q];
        rd_coef_o  = bank_q[rd_ptr_q][rd_pos_i[5:3]][rd_pos_i[2:0]];
        nxt_head_o = bank_q[~rd_ptr_q][0][0];
    end

endmodule

// File: rtl/quant_block_scan.sv
// Quantized 8x8 block to scan-order coefficient stream with a ping-pong input
// buffer. Optional macro QUANT_BLOCK_SCAN_INTERLACE_EN adds the INTERLACED input
// selecting the interlaced scan table per block; otherwise progressive scan only.
module quant_block_scan
    import quant_scan_pkg::*;
#(
    parameter int DATA_WIDTH = 32
)
(
    input  logic                         CLOCK,
    input  logic                         RESET,
    input  logic signed [DATA_WIDTH-1:0] INPUT_DATA [8][8],
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    output logic signed [DATA_WIDTH-1:0] OUT_DATA,
    output logic [5:0]                   OUT_INDEX,
    output logic                         OUT_FIRST,
    output logic                         OUT_LAST,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY
`ifdef QUANT_BLOCK_SCAN_INTERLACE_EN
    ,
    input  logic                         INTERLACED
`endif
);

    scan_state_e                  state_q;
    logic signed [DATA_WIDTH-1:0] data_q;
    logic [5:0]                   index_q;
    logic                         first_q;
    logic                         last_q;
    logic                         valid_q;

    logic                         intl_in_s;
    logic                         xfer_s;
    logic                         drain_s;
    logic                         accept_s;
    logic                         in_ready_s;
    logic                         wr_ready_s;
    logic                         rd_full_s;
    logic                         nxt_full_s;
    logic                         rd_intl_s;
    logic [5:0]                   rd_pos_s;
    logic signed [DATA_WIDTH-1:0] rd_coef_s;
    logic signed [DATA_WIDTH-1:0] nxt_head_s;

`ifdef QUANT_BLOCK_SCAN_INTERLACE_EN
    assign intl_in_s = INTERLACED;
`else
    assign intl_in_s = 1'b0;
`endif

    // Output-side handshake and the bank position of the next beat to load.
    always_comb begin
        xfer_s  = valid_q && OUT_READY;
        drain_s = xfer_s && (index_q == LAST_IDX);
        if (state_q == ST_IDLE) begin
            rd_pos_s = 6'd0;
        end else begin
            rd_pos_s = scan_pos(rd_intl_s, index_q + 6'd1);
        end
    end

    // Input-side handshake; held off entirely while reset is asserted.
    always_comb begin
        in_ready_s = RESET && wr_ready_s;
        accept_s   = IN_VALID && in_ready_s;
    end

    quant_block_pingpong #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pingpong (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .wr_en_i    (accept_s),
        .wr_data_i  (INPUT_DATA),
        .wr_intl_i  (intl_in_s),
        .drain_i    (drain_s),
        .rd_pos_i   (rd_pos_s),
        .wr_ready_o (wr_ready_s),
        .rd_full_o  (rd_full_s),
        .nxt_full_o (nxt_full_s),
        .rd_intl_o  (rd_intl_s),
        .rd_coef_o  (rd_coef_s),
        .nxt_head_o (nxt_head_s)
    );

    // Read FSM with the registered beat. Both scan tables start at position 0,
    // so the first beat of a block is always element [0][0]; a block arriving
    // this cycle is forwarded straight from INPUT_DATA to keep latency at one.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            index_q <= 6'd0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rd_full_s || accept_s) begin
                        state_q <= ST_EMIT;
                        data_q  <= rd_full_s ? rd_coef_s : INPUT_DATA[0][0];
                        index_q <= 6'd0;
                        first_q <= 1'b1;
                        last_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                ST_EMIT: begin
                    if (xfer_s) begin
                        if (index_q != LAST_IDX) begin
                            data_q  <= rd_coef_s;
                            index_q <= index_q + 6'd1;
                            first_q <= 1'b0;
                            last_q  <= (index_q == 6'd62);
                        end else if (nxt_full_s || accept_s) begin
                            data_q  <= nxt_full_s ? nxt_head_s : INPUT_DATA[0][0];
                            index_q <= 6'd0;
                            first_q <= 1'b1;
                            last_q  <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                            data_q  <= '0;
                            index_q <= 6'd0;
                            first_q <= 1'b0;
                            last_q  <= 1'b0;
                            valid_q <= 1'b0;
                        end
                    end else begin
                        state_q <= ST_EMIT;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    data_q  <= '0;
                    index_q <= 6'd0;
                    first_q <= 1'b0;
                    last_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign IN_READY  = in_ready_s;
    assign OUT_DATA  = data_q;
    assign OUT_INDEX = index_q;
    assign OUT_FIRST = first_q;
    assign OUT_LAST  = last_q;
    assign OUT_VALID = valid_q;

endmodule

// File: tb/tb_quant_block_scan.sv
// Self-checking bench for quant_block_scan: directed steps with random data and
// a scoreboard that derives each expected beat from the scan tables.
module tb_quant_block_scan;

    typedef logic signed [31:0] blk_t [8][8];

    logic        CLOCK = 1'b0;
    logic        RESET;
    blk_t        in_data;
    logic        IN_VALID;
    logic        IN_READY;
    logic signed [31:0] OUT_DATA;
    logic [5:0]  OUT_INDEX;
    logic        OUT_FIRST;
    logic        OUT_LAST;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic        intl_drv;
    logic        rand_rdy;

    int checks   = 0;
    int failures = 0;

    int prog_tab [64] = '{0,1,8,9,2,3,10,11,16,17,24,25,18,19,26,27,4,5,12,20,13,6,7,14,
                          21,28,29,22,15,23,30,31,32,33,40,48,41,34,35,42,49,56,57,50,43,36,37,44,
                          51,58,59,52,45,38,39,46,53,60,61,54,47,55,62,63};
    int intl_tab [64] = '{0,8,1,9,16,24,17,25,2,10,3,11,18,26,19,27,32,40,33,34,41,48,56,49,
                          42,35,43,50,57,58,51,59,4,12,5,6,13,20,28,21,14,7,15,22,29,36,44,37,
                          30,23,31,38,45,52,60,53,46,39,47,54,61,62,55,63};

    logic signed [31:0] exp_d [$];
    int                 exp_i [$];

    logic               prev_stall = 1'b0;
    logic signed [31:0] prev_data;
    logic [5:0]         prev_idx;
    logic               prev_first;
    logic               prev_last;

    always #5 CLOCK = ~CLOCK;

    quant_block_scan #(.DATA_WIDTH(32)) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .INPUT_DATA (in_data),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .OUT_DATA   (OUT_DATA),
        .OUT_INDEX  (OUT_INDEX),
        .OUT_FIRST  (OUT_FIRST),
        .OUT_LAST   (OUT_LAST),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY)
`ifdef QUANT_BLOCK_SCAN_INTERLACE_EN
        ,
        .INTERLACED (intl_drv)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected stream for one accepted block: beat k carries element SCAN[k].
    task automatic model_push(input logic intl);
        int s;
        for (int k = 0; k < 64; k++) begin
            s = intl ? intl_tab[k] : prog_tab[k];
            exp_d.push_back(in_data[s / 8][s % 8]);
            exp_i.push_back(k);
        end
    endtask

    // Scoreboard and stall-stability monitor, sampled on the falling edge.
    always @(negedge CLOCK) begin
        if (RESET !== 1'b1) begin
            exp_d.delete();
            exp_i.delete();
            prev_stall = 1'b0;
        end else begin
            if (IN_VALID && IN_READY) model_push(intl_drv);
            if (OUT_VALID) begin
                if (prev_stall) begin
                    chk("stall_data", OUT_DATA, prev_data);
                    chk("stall_index", OUT_INDEX, prev_idx);
                    chk("stall_first", OUT_FIRST, prev_first);
                    chk("stall_last", OUT_LAST, prev_last);
                end
                if (exp_d.size() == 0) begin
                    chk("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    chk("beat_data", OUT_DATA, exp_d[0]);
                    chk("beat_index", OUT_INDEX, exp_i[0]);
                    chk("beat_first", OUT_FIRST, exp_i[0] == 0);
                    chk("beat_last", OUT_LAST, exp_i[0] == 63);
                    if (OUT_READY) begin
                        void'(exp_d.pop_front());
                        void'(exp_i.pop_front());
                    end
                end
                prev_stall = !OUT_READY;
                prev_data  = OUT_DATA;
                prev_idx   = OUT_INDEX;
                prev_first = OUT_FIRST;
                prev_last  = OUT_LAST;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge CLOCK);
        #1;
        if (rand_rdy) OUT_READY = ($urandom_range(0, 1) == 1);
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                in_data[r][c] = r * 8 + c;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                in_data[r][c] = $urandom;
        in_data[0][1] = -32'sd5;
        in_data[3][4] = 32'h7FFF_FFFF;
        in_data[7][7] = 32'h8000_0000;
        in_data[$urandom_range(0, 7)][$urandom_range(0, 7)] = -32'sd5;
    endtask

    // Present the current in_data until it is accepted (bounded wait).
    task automatic send_block(input logic intl);
        logic acc;
        acc      = 1'b0;
        IN_VALID = 1'b1;
        intl_drv = intl;
        for (int n = 0; n < 1000; n++) begin
            @(negedge CLOCK);
            acc = IN_READY;
            step();
            if (acc) break;
        end
        IN_VALID = 1'b0;
        chk("block_accepted", acc, 1'b1);
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 3000; n++) begin
            @(negedge CLOCK);
            if (exp_d.size() == 0) break;
            step();
        end
        chk("drain_done", exp_d.size() == 0, 1'b1);
        step();
        @(negedge CLOCK);
        chk("idle_after_drain", OUT_VALID, 1'b0);
        step();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, OUT_VALID, 1'b0);
        chk({tag, "_data"}, OUT_DATA, 32'sd0);
        chk({tag, "_index"}, OUT_INDEX, 6'd0);
        chk({tag, "_first"}, OUT_FIRST, 1'b0);
        chk({tag, "_last"}, OUT_LAST, 1'b0);
        chk({tag, "_in_ready"}, IN_READY, 1'b0);
    endtask

    initial begin
        RESET     = 1'b0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        intl_drv  = 1'b0;
        rand_rdy  = 1'b0;
        fill_ramp();

        // Reset state
        repeat (3) step();
        @(negedge CLOCK);
        chk_zero_outputs("reset");
        step();
        RESET = 1'b1;
        @(negedge CLOCK);
        chk("ready_after_reset", IN_READY, 1'b1);
        chk("valid_after_reset", OUT_VALID, 1'b0);
        step();

        // Ramp block, full-rate consumer, latency one
        fill_ramp();
        send_block(1'b0);
        @(negedge CLOCK);
        chk("lat_valid", OUT_VALID, 1'b1);
        chk("lat_index", OUT_INDEX, 6'd0);
        chk("lat_first", OUT_FIRST, 1'b1);
        chk("lat_data", OUT_DATA, 32'sd0);
        step();
        wait_drain();

        // Two blocks back to back, no bubble between them
        fill_rand();
        IN_VALID = 1'b1;
        @(negedge CLOCK);
        chk("b2b_ready_first", IN_READY, 1'b1);
        step();
        fill_rand();
        @(negedge CLOCK);
        chk("b2b_ready_second", IN_READY, 1'b1);
        chk("b2b_beat0", OUT_INDEX, 6'd0);
        step();
        IN_VALID = 1'b0;
        for (int i = 1; i < 64; i++) begin
            @(negedge CLOCK);
            chk("b2b_in_ready", IN_READY, i == 63);
            chk("b2b_index", OUT_INDEX, i);
            step();
        end
        @(negedge CLOCK);
        chk("b2b_gap_valid", OUT_VALID, 1'b1);
        chk("b2b_gap_index", OUT_INDEX, 6'd0);
        chk("b2b_gap_first", OUT_FIRST, 1'b1);
        step();
        wait_drain();

        // Random back-pressure with signed extremes
        rand_rdy = 1'b1;
        for (int b = 0; b < 3; b++) begin
            fill_rand();
            send_block(1'b0);
            repeat ($urandom_range(0, 3)) step();
        end
        wait_drain();
        rand_rdy  = 1'b0;
        OUT_READY = 1'b1;
        step();

        // Reset in the middle of a block with another block pending
        fill_rand();
        send_block(1'b0);
        fill_rand();
        send_block(1'b0);
        for (int n = 0; n < 300; n++) begin
            @(negedge CLOCK);
            if (OUT_VALID && OUT_INDEX == 6'd29) break;
            step();
        end
        chk("reached_beat29", OUT_INDEX, 6'd29);
        step();
        RESET = 1'b0;
        @(negedge CLOCK);
        chk("beat30_at_reset", OUT_INDEX, 6'd30);
        step();
        @(negedge CLOCK);
        chk_zero_outputs("midreset");
        step();
        RESET = 1'b1;
        @(negedge CLOCK);
        chk("ready_after_midreset", IN_READY, 1'b1);
        chk("no_stale_beat", OUT_VALID, 1'b0);
        step();
        fill_rand();
        send_block(1'b0);
        @(negedge CLOCK);
        chk("restart_index", OUT_INDEX, 6'd0);
        chk("restart_data", OUT_DATA, in_data[0][0]);
        step();
        wait_drain();

`ifdef QUANT_BLOCK_SCAN_INTERLACE_EN
        // Interlaced block followed by a progressive one
        fill_rand();
        send_block(1'b1);
        fill_rand();
        send_block(1'b0);
        wait_drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
